// File: rtl/exe_pkg.sv
// Shared widths and bypass-entry layout for the EXE->MEM buffer.
// Imported by exe_bypass_fifo.
package exe_pkg;

  localparam int XLEN   = 32;
  localparam int DEST_W = 6;

  localparam logic [DEST_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [XLEN-1:0]   res;
    logic              wb;
    logic              load;
  } byp_entry_t;

endpackage

// File: rtl/byp_prio_sel.sv
// Youngest-match picker: match vector + wr ptr -> one-hot select.
// Ports: match (per entry), wr_ptr (next write slot), sel (one-hot or 0).
module byp_prio_sel #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] wr_ptr,
  output logic [DEPTH-1:0] sel
);

  int idx;

  // Walk oldest (k=DEPTH) to youngest (k=1) behind wr_ptr;
  // the last hit seen is the youngest and overrides older ones.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = int'(wr_ptr) - k;
      if (idx < 0) begin
        idx = idx + DEPTH;
      end
      if (match[idx]) begin
        sel      = '0;
        sel[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exe_bypass_fifo.sv
// EXE->MEM FWFT buffer of DEPTH results with NUM_LKP bypass lookups.
// Ports: push/pop/flush side, DOUT/FULL/EMPTY/COUNT/ERR_OVF, LKP_*.
module exe_bypass_fifo #(
  parameter int WIDTH   = 200,
  parameter int DEPTH   = 2,
  parameter int XLEN    = 32,
  parameter int DEST_W  = 6,
  parameter int NUM_LKP = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      PUSH,
  input  logic [WIDTH-1:0]          DIN,
  input  logic [DEST_W-1:0]         DIN_DEST,
  input  logic [XLEN-1:0]           DIN_RES,
  input  logic                      DIN_WB,
  input  logic                      DIN_LOAD,
  input  logic                      POP,
  input  logic                      FLUSH,
  output logic [WIDTH-1:0]          DOUT,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                      ERR_OVF,
  input  logic [NUM_LKP*DEST_W-1:0] LKP_ADR,
  output logic [NUM_LKP-1:0]        LKP_HIT,
  output logic [NUM_LKP*XLEN-1:0]   LKP_DATA,
  output logic [NUM_LKP-1:0]        LKP_BLOCK
);

  import exe_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pay_q [DEPTH];
  logic [WIDTH-1:0] pay_d [DEPTH];
  byp_entry_t       ent_q [DEPTH];
  byp_entry_t       ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic full, empty;
  logic push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] nxt_ptr(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = PUSH && (!full || POP);
  assign pop_ok  = POP && !empty;

  always_comb begin
    pay_d = pay_q;
    ent_d = ent_q;
    vld_d = vld_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = PUSH && full && !POP && !FLUSH;
    if (FLUSH) begin
      vld_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (pop_ok) begin
        vld_d[rd_q] = 1'b0;
        rd_d        = nxt_ptr(rd_q);
      end
      // Push after pop: on full push+pop rd==wr, slot stays valid.
      if (push_ok) begin
        pay_d[wr_q]      = DIN;
        ent_d[wr_q].dest = DIN_DEST;
        ent_d[wr_q].res  = DIN_RES;
        ent_d[wr_q].wb   = DIN_WB;
        ent_d[wr_q].load = DIN_LOAD;
        vld_d[wr_q]      = 1'b1;
        wr_d             = nxt_ptr(wr_q);
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pay_q[i] <= '0;
        ent_q[i] <= '0;
      end
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pay_q <= pay_d;
      ent_q <= ent_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign DOUT    = pay_q[rd_q];
  assign FULL    = full;
  assign EMPTY   = empty;
  assign COUNT   = cnt_q;
  assign ERR_OVF = ovf_q;

  for (genvar c = 0; c < NUM_LKP; c++) begin : g_lkp
    logic [DEST_W-1:0] adr;
    logic [DEPTH-1:0]  match;
    logic [DEPTH-1:0]  sel;
    logic [XLEN-1:0]   data;
    logic              is_ld;

    assign adr = LKP_ADR[c*DEST_W +: DEST_W];

    always_comb begin
      match = '0;
      for (int e = 0; e < DEPTH; e++) begin
        match[e] = vld_q[e] && ent_q[e].wb &&
                   (ent_q[e].dest == adr) &&
                   (adr != REG_ZERO);
      end
    end

    byp_prio_sel #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
    ) u_sel (
      .match  (match),
      .wr_ptr (wr_q),
      .sel    (sel)
    );

    always_comb begin
      data  = '0;
      is_ld = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        if (sel[e]) begin
          data  = data | ent_q[e].res;
          is_ld = is_ld | ent_q[e].load;
        end
      end
    end

    // A younger pending load hides any older ALU result.
    assign LKP_HIT[c]   = (|sel) && !is_ld;
    assign LKP_BLOCK[c] = (|sel) && is_ld;
    assign LKP_DATA[c*XLEN +: XLEN] = is_ld ? '0 : data;
  end

endmodule

// File: tb/tb_exe_bypass_fifo.sv
// Scoreboard bench for exe_bypass_fifo (DEPTH=3, two lookups).
// Queue-based reference model; negedge monitor compares.
module tb_exe_bypass_fifo;

  localparam int W  = 40;
  localparam int D  = 3;
  localparam int XL = 32;
  localparam int DW = 6;
  localparam int NL = 2;
  localparam int CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            PUSH, POP, FLUSH;
  logic [W-1:0]    DIN;
  logic [DW-1:0]   DIN_DEST;
  logic [XL-1:0]   DIN_RES;
  logic            DIN_WB, DIN_LOAD;
  logic [W-1:0]    DOUT;
  logic            FULL, EMPTY, ERR_OVF;
  logic [CW-1:0]   COUNT;
  logic [NL*DW-1:0] LKP_ADR;
  logic [NL-1:0]   LKP_HIT, LKP_BLOCK;
  logic [NL*XL-1:0] LKP_DATA;

  always #5 clk = ~clk;

  exe_bypass_fifo #(
    .WIDTH   (W),
    .DEPTH   (D),
    .XLEN    (XL),
    .DEST_W  (DW),
    .NUM_LKP (NL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PUSH      (PUSH),
    .DIN       (DIN),
    .DIN_DEST  (DIN_DEST),
    .DIN_RES   (DIN_RES),
    .DIN_WB    (DIN_WB),
    .DIN_LOAD  (DIN_LOAD),
    .POP       (POP),
    .FLUSH     (FLUSH),
    .DOUT      (DOUT),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .ERR_OVF   (ERR_OVF),
    .LKP_ADR   (LKP_ADR),
    .LKP_HIT   (LKP_HIT),
    .LKP_DATA  (LKP_DATA),
    .LKP_BLOCK (LKP_BLOCK)
  );

  typedef struct {
    logic [W-1:0]  pay;
    logic [DW-1:0] dest;
    logic [XL-1:0] res;
    bit            wb;
    bit            ld;
  } ment_t;

  typedef struct {
    bit               empty;
    bit               full;
    int               count;
    bit               chk_dout;
    logic [W-1:0]     dout;
    bit               ovf;
    logic [NL-1:0]    hit;
    logic [NL-1:0]    blk;
    logic [NL*XL-1:0] data;
  } exp_t;

  ment_t mq[$];
  exp_t  exp_q[$];
  bit    m_ok   = 1'b0;
  bit    m_ovf  = 1'b0;
  bit    m_zero = 1'b0;
  int    n_vec  = 0;
  int    n_err  = 0;

  function automatic void chk(
    input string      n,
    input logic [63:0] a,
    input logic [63:0] x
  );
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               n, a, x, $time);
    end
  endfunction

  // Youngest writer of adr decides: load -> block, else forward.
  function automatic void lkp(
    input  logic [DW-1:0] a,
    output bit            h,
    output bit            b,
    output logic [XL-1:0] v
  );
    h = 1'b0;
    b = 1'b0;
    v = '0;
    if (a == '0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].dest == a && mq[i].wb) begin
        if (mq[i].ld) b = 1'b1;
        else begin
          h = 1'b1;
          v = mq[i].res;
        end
        return;
      end
    end
  endfunction

  task automatic step(
    input bit            rst,
    input bit            ps,
    input bit            pp,
    input bit            fl,
    input logic [DW-1:0] d,
    input logic [XL-1:0] r,
    input bit            wb,
    input bit            ld,
    input logic [DW-1:0] a0,
    input logic [DW-1:0] a1
  );
    exp_t          e;
    logic [63:0]   rnd;
    bit            h, b, full, popped, pushed;
    logic [XL-1:0] v;
    ment_t         m;
    rnd      = {$urandom(), $urandom()};
    reset    = rst;
    PUSH     = ps;
    POP      = pp;
    FLUSH    = fl;
    DIN      = rnd[W-1:0];
    DIN_DEST = d;
    DIN_RES  = r;
    DIN_WB   = wb;
    DIN_LOAD = ld;
    LKP_ADR  = {a1, a0};
    if (m_ok) begin
      e.empty    = (mq.size() == 0);
      e.full     = (mq.size() == D);
      e.count    = mq.size();
      e.chk_dout = (mq.size() > 0) || m_zero;
      e.dout     = (mq.size() > 0) ? mq[0].pay : '0;
      e.ovf      = m_ovf;
      e.hit      = '0;
      e.blk      = '0;
      e.data     = '0;
      lkp(a0, h, b, v);
      e.hit[0] = h;
      e.blk[0] = b;
      e.data[XL-1:0] = v;
      lkp(a1, h, b, v);
      e.hit[1] = h;
      e.blk[1] = b;
      e.data[2*XL-1:XL] = v;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_zero = 1'b1;
      m_ok   = 1'b1;
    end else if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      full   = (mq.size() == D);
      m_ovf  = ps && full && !pp;
      popped = pp && (mq.size() > 0);
      pushed = ps && (!full || pp);
      if (popped) void'(mq.pop_front());
      if (pushed) begin
        m.pay  = DIN;
        m.dest = d;
        m.res  = r;
        m.wb   = wb;
        m.ld   = ld;
        mq.push_back(m);
        m_zero = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [DW-1:0] a0,
                      input logic [DW-1:0] a1);
    step(0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  task automatic push(input logic [DW-1:0] d,
                      input logic [XL-1:0] r,
                      input bit ld);
    step(0, 1, 0, 0, d, r, 1, ld, d, 0);
  endtask

  task automatic pop(input logic [DW-1:0] a0);
    step(0, 0, 1, 0, 0, 0, 0, 0, a0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("empty", 64'(EMPTY), 64'(e.empty));
      chk("full", 64'(FULL), 64'(e.full));
      chk("count", 64'(COUNT), 64'(e.count));
      chk("err_ovf", 64'(ERR_OVF), 64'(e.ovf));
      if (e.chk_dout) chk("dout", 64'(DOUT), 64'(e.dout));
      chk("lkp_hit", 64'(LKP_HIT), 64'(e.hit));
      chk("lkp_block", 64'(LKP_BLOCK), 64'(e.blk));
      chk("lkp_data", 64'(LKP_DATA), 64'(e.data));
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      idle(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
    end

    // overfill, then drain in order
    for (int i = 1; i <= D + 1; i++) begin
      push(6'(i), 32'(i * 16), 0);
    end
    idle(1, 2);
    for (int i = 0; i < D; i++) pop(6'(i + 1));
    idle(1, 3);
    pop(0);

    // steady push+pop at full across pointer wrap
    for (int i = 0; i < D; i++) push(6'(10 + i), 32'(i), 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, 6'(20 + i), 32'($urandom()),
           1, 0, 6'(20 + i), 6'(19 + i));
    end
    for (int i = 0; i < D; i++) pop(0);

    // youngest wins, x0 never matches
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    push(5, 32'h11, 0);
    push(5, 32'h22, 0);
    idle(5, 0);
    step(0, 1, 0, 0, 0, 32'h33, 1, 0, 5, 0);
    idle(0, 5);

    // pending load blocks the older ALU value
    step(0, 0, 0, 1, 0, 0, 0, 0, 7, 0);
    push(7, 32'hAA, 0);
    push(7, 32'h0, 1);
    idle(7, 7);
    pop(7);
    pop(7);
    idle(7, 0);

    // flush beats push; reset mid-stream
    push(3, 32'h5, 0);
    push(4, 32'h6, 0);
    step(0, 1, 1, 1, 3, 32'h7, 1, 0, 3, 4);
    idle(3, 4);
    push(2, 32'h8, 0);
    push(2, 32'h9, 1);
    step(1, 1, 1, 1, 2, 32'h1, 1, 0, 2, 2);
    idle(2, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 4,
           6'($urandom_range(0, 3)),
           32'($urandom()),
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 3,
           6'($urandom_range(0, 3)),
           6'($urandom_range(0, 3)));
    end
    idle(0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
